// File: rtl/spi_adc_scanner.sv
// Round-robin SPI scanner for MCP3208-style ADCs (SPI mode 0).
// Handshake: o_valid holds the latest word until a clock with i_ready=1; a new load overwrites an unconsumed word and pulses o_overrun.
module spi_adc_scanner #(
    parameter int CLK_DIV       = 4,
    parameter int RES_BITS      = 12,
    parameter int NUM_CH        = 8,
    parameter int SGL           = 1,
    parameter int SAMPLE_PERIOD = 2500,
    parameter int CSH_CYCLES    = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                miso,
    output logic                mosi,
    output logic                sck,
    output logic                cs_n,
    output logic [RES_BITS-1:0] o_data,
    output logic [2:0]          o_ch,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_overrun,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SETUP = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int CSH_W = $clog2(CSH_CYCLES + 1) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [CSH_W-1:0] CSH_FULL  = CSH_W'(CSH_CYCLES);
    localparam logic [CSH_W-1:0] CSH_HOLD  = CSH_W'((CSH_CYCLES > 0) ? CSH_CYCLES - 1 : 0);
    localparam logic [4:0]       LAST_EDGE = 5'(7 + RES_BITS);
    localparam logic [2:0]       CH_LAST   = 3'(NUM_CH - 1);
    localparam logic             SGL_BIT   = (SGL != 0);

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [4:0]          edge_q, edge_d;
    logic [PER_W-1:0]    per_q, per_d;
    logic [CSH_W-1:0]    csh_q, csh_d;
    logic                pend_q, pend_d;
    logic [2:0]          ch_q, ch_d;
    logic [RES_BITS-1:0] sr_q, sr_d;
    logic                cs_n_d, sck_d, mosi_d;
    logic [RES_BITS-1:0] o_data_d;
    logic [2:0]          o_ch_d;
    logic                o_valid_d, o_overrun_d;
    logic                go, load, tick;

    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            per_q     <= '0;
            csh_q     <= CSH_FULL;
            pend_q    <= 1'b0;
            ch_q      <= '0;
            sr_q      <= '0;
            cs_n      <= 1'b1;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            o_data    <= '0;
            o_ch      <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            per_q     <= per_d;
            csh_q     <= csh_d;
            pend_q    <= pend_d;
            ch_q      <= ch_d;
            sr_q      <= sr_d;
            cs_n      <= cs_n_d;
            sck       <= sck_d;
            mosi      <= mosi_d;
            o_data    <= o_data_d;
            o_ch      <= o_ch_d;
            o_valid   <= o_valid_d;
            o_overrun <= o_overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        edge_d      = edge_q;
        sr_d        = sr_q;
        ch_d        = ch_q;
        cs_n_d      = cs_n;
        sck_d       = sck;
        mosi_d      = mosi;
        o_data_d    = o_data;
        o_ch_d      = o_ch;
        o_valid_d   = o_valid;
        o_overrun_d = 1'b0;
        go          = 1'b0;
        load        = 1'b0;
        tick        = (state_q != ST_IDLE) && (per_q == '0);
        per_d       = (state_q == ST_IDLE || per_q == PER_LAST) ? '0 : per_q + PER_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_WAIT;
            end
            // A period tick missed while busy is remembered so overlong frames run back to back.
            ST_WAIT: begin
                if ((tick || pend_q) && csh_q >= CSH_FULL) begin
                    go      = 1'b1;
                    state_d = ST_SETUP;
                    cs_n_d  = 1'b0;
                    mosi_d  = 1'b1;
                    div_d   = '0;
                end
            end
            ST_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = ST_SHIFT;
                    sck_d   = 1'b1;
                    edge_d  = 5'd1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (sck) begin
                        sck_d = 1'b0;
                        case (edge_q)
                            5'd1:    mosi_d = SGL_BIT;
                            5'd2:    mosi_d = ch_q[2];
                            5'd3:    mosi_d = ch_q[1];
                            5'd4:    mosi_d = ch_q[0];
                            default: mosi_d = 1'b0;
                        endcase
                    end else if (edge_q == LAST_EDGE) begin
                        load    = 1'b1;
                        cs_n_d  = 1'b1;
                        state_d = ST_HOLD;
                        ch_d    = (ch_q >= CH_LAST) ? 3'd0 : ch_q + 3'd1;
                    end else begin
                        sck_d  = 1'b1;
                        edge_d = edge_q + 5'd1;
                        // Rising edges 1..7 carry command, sample and null bits; data starts at edge 8.
                        if (edge_q >= 5'd7) sr_d = {sr_q[RES_BITS-2:0], miso};
                    end
                end
            end
            ST_HOLD: begin
                if (csh_q >= CSH_HOLD) state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase

        if (!en && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            cs_n_d  = 1'b1;
            sck_d   = 1'b0;
            mosi_d  = 1'b0;
            ch_d    = '0;
            div_d   = '0;
            edge_d  = '0;
            per_d   = '0;
            go      = 1'b0;
            load    = 1'b0;
        end

        pend_d = (state_d != ST_IDLE) && !go && (pend_q || tick);
        // Counts clocks since cs_n last rose; the WAIT->SETUP edge is exactly CSH_CYCLES later.
        csh_d  = (!cs_n && cs_n_d) ? CSH_W'(1) :
                 (csh_q >= CSH_FULL) ? csh_q : csh_q + CSH_W'(1);

        if (load) begin
            o_data_d    = sr_q;
            o_ch_d      = ch_q;
            o_valid_d   = 1'b1;
            o_overrun_d = o_valid && !i_ready;
        end else if (o_valid && i_ready) begin
            o_valid_d = 1'b0;
        end
    end

endmodule

// File: doc/spi_adc_scanner.md
SPI_ADC_SCANNER -- requirements
Module: spi_adc_scanner

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per SCK half-period; legal range is 2 or more.
REQ-002 Parameter RES_BITS, default 12: ADC result width; legal range is 8 to 16.
REQ-003 Parameter NUM_CH, default 8: number of channels scanned round-robin; legal range is 1 to 8.
REQ-004 Parameter SGL, default 1: 1 selects single-ended mode, 0 selects differential mode.
REQ-005 Parameter SAMPLE_PERIOD, default 2500: clocks from one frame start to the next frame start.
REQ-006 Parameter CSH_CYCLES, default 64: minimum clocks cs_n is held high between frames.
REQ-007 Port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-008 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 Port en, input, 1 bit: scan enable, active high.
REQ-010 Port miso, input, 1 bit: ADC Dout.
REQ-011 Port mosi, output, 1 bit: ADC Din.
REQ-012 Port sck, output, 1 bit: SPI clock, idle low (mode 0).
REQ-013 Port cs_n, output, 1 bit: chip select, active low.
REQ-014 Port o_data, output, RES_BITS bits: latest conversion result.
REQ-015 Port o_ch, output, 3 bits: channel number of o_data.
REQ-016 Port o_valid, output, 1 bit: result available.
REQ-017 Port i_ready, input, 1 bit: consumer accepts the result.
REQ-018 Port o_overrun, output, 1 bit: one-clock pulse when an unconsumed result is overwritten.

Function
REQ-019 The block SHALL implement states IDLE, WAIT, SETUP, SHIFT and HOLD.
REQ-020 IDLE SHALL move to WAIT when en=1, and the period counter SHALL be 0 on that entry.
REQ-021 The period counter SHALL run 0 to SAMPLE_PERIOD-1 and wrap while en=1.
- WAIT SHALL move to SETUP when the counter is 0 and at least CSH_CYCLES clocks have elapsed since cs_n last rose.
REQ-022 SETUP SHALL drive cs_n=0 and mosi=1 (start bit) and hold them for CLK_DIV clocks, then move to SHIFT.
REQ-023 SHIFT SHALL produce exactly 7+RES_BITS SCK cycles, each CLK_DIV clocks high followed by CLK_DIV clocks low.
REQ-024 The command bits SHALL be presented MSB-first as start, SGL, CH[2], CH[1], CH[0].
- mosi SHALL update on each SCK falling edge.
- mosi SHALL be 0 after the 5th SCK falling edge.
REQ-025 miso SHALL be sampled on SCK rising edges 8 through 7+RES_BITS (counted from 1), MSB first.
- Rising edges 6 and 7 (sample period and null bit) SHALL be ignored.
REQ-026 After the final SCK falling edge, the block SHALL drive cs_n=1 and, in the same clock, load the shifted word into o_data and the current channel into o_ch, set o_valid=1, and enter HOLD.
REQ-027 HOLD SHALL last CSH_CYCLES clocks, then go to WAIT.
- The channel index SHALL advance by one, wrapping from NUM_CH-1 to 0.
REQ-028 o_valid SHALL clear on any clock where o_valid=1 and i_ready=1, unless a new load occurs in that same clock.
- A new load in that clock SHALL win and leave o_valid=1.
REQ-029 When a load occurs with o_valid=1 and i_ready=0, o_data and o_ch SHALL be overwritten and o_overrun SHALL pulse for one clock.
REQ-030 A simultaneous load and i_ready=1 SHALL NOT raise o_overrun.
REQ-031 If SAMPLE_PERIOD is smaller than CLK_DIV*(15+2*RES_BITS)+CSH_CYCLES, frames SHALL run back to back with exactly CSH_CYCLES of cs_n high between them.
REQ-032 If en falls in any state, on the next clock the block SHALL:
- drive cs_n=1, sck=0 and mosi=0;
- discard the partial word, with no o_valid or o_overrun;
- reset the channel index to 0;
- go to IDLE.
REQ-033 With NUM_CH=1, CH[2:0] SHALL always be 0.
REQ-034 With SGL=0, the CH bits SHALL select the differential pair per the ADC datasheet channel table.

Reset
REQ-035 While reset=1, the outputs SHALL be: cs_n=1, sck=0, mosi=0, o_data=0, o_ch=0, o_valid=0, o_overrun=0.
- Also: state=IDLE, channel index=0, period counter=0.
REQ-036 Deassertion of reset SHALL be followed by normal operation from IDLE.
REQ-037 Reset asserted mid-frame SHALL force the REQ-035 values immediately, without waiting for a clock edge.

Verification
REQ-038 Basic frame (CLK_DIV=4, RES_BITS=12, NUM_CH=4, SAMPLE_PERIOD=200, CSH_CYCLES=8), en=1, ADC model returns 0xA5C on channel 0:
- cs_n low for 156 clocks;
- 19 SCK pulses, 8 clocks each;
- mosi bits 1,1,0,0,0;
- o_data=0xA5C, o_ch=0, o_valid=1 on the clock cs_n rises.
REQ-039 Scan, same configuration, i_ready=1: o_ch sequence 0,1,2,3,0, with frame starts exactly 200 clocks apart.
REQ-040 Overrun, i_ready=0 for two frames: second load overwrites o_data, o_overrun high for one clock, o_valid stays 1.
- Raising i_ready then clears o_valid on the next clock.
REQ-041 Abort, en dropped at SCK pulse 10:
- next clock cs_n=1, sck=0;
- no o_valid;
- after en=1 again, the first frame uses channel 0.
REQ-042 Back-to-back, SAMPLE_PERIOD=50: consecutive frames separated by exactly 8 clocks of cs_n high.
REQ-043 Async reset asserted mid-SHIFT between clock edges: all outputs take their reset values before the next clk edge.
